// File: rtl/sub_pipe_pkg.sv
// Shared constants and record types for the pipelined subtractor.
package sub_pipe_pkg;

  localparam int SP_WIDTH = 16;
  localparam int SP_GROUP = 4;

  // One pipeline slot: diff bits resolved so far, carry into the next group,
  // and the operands (minuend and inverted subtrahend) still to be consumed.
  typedef struct packed {
    logic                valid;
    logic                carry;
    logic [SP_WIDTH-1:0] diff;
    logic [SP_WIDTH-1:0] a;
    logic [SP_WIDTH-1:0] nb;
  } stage_t;

  typedef struct packed {
    logic [SP_WIDTH-1:0] diff;
    logic                borrow;
    logic                lt_s;
    logic                zero;
  } result_t;

endpackage

// File: rtl/sub_group.sv
// Combinational GROUP-bit carry-lookahead slice computing a + nb + cin.
module sub_group
  import sub_pipe_pkg::*;
#(
  parameter int GROUP = SP_GROUP
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] nb,
  input  logic             cin,
  output logic [GROUP-1:0] s,
  output logic             cout,
  output logic             g,
  output logic             p
);
  logic [GROUP-1:0] gb, pb, gg, pp;
  logic [GROUP:0]   c;
  logic             prop;

  assign gb = a & nb;
  assign pb = a | nb;

  // gg[i]/pp[i]: generate/propagate of bits i..0, flattened so every carry is
  // a two-level function of the bit terms and cin.
  always_comb begin
    gg   = '0;
    pp   = '0;
    c    = '0;
    prop = 1'b1;
    c[0] = cin;
    for (int i = 0; i < GROUP; i++) begin
      gg[i] = gb[i];
      prop  = pb[i];
      for (int j = i - 1; j >= 0; j--) begin
        gg[i] = gg[i] | (prop & gb[j]);
        prop  = prop & pb[j];
      end
      pp[i]   = prop;
      c[i+1]  = gg[i] | (pp[i] & cin);
    end
  end

  assign s    = a ^ nb ^ c[GROUP-1:0];
  assign cout = c[GROUP];
  assign g    = gg[GROUP-1];
  assign p    = pp[GROUP-1];

endmodule

// File: rtl/sub_pipe.sv
// Pipelined subtractor: a - b as a + ~b + 1, one lookahead group per stage,
// carry registered between stages, valid/ready streaming on both sides.
module sub_pipe
  import sub_pipe_pkg::*;
#(
  parameter int WIDTH = SP_WIDTH,
  parameter int GROUP = SP_GROUP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_diff,
  output logic             out_borrow,
  output logic             out_lt_s,
  output logic             out_zero
);
  localparam int STAGES = WIDTH / GROUP;
  localparam int LAST   = STAGES - 1;

  stage_t            st_reg   [STAGES];
  stage_t            st_next  [STAGES];
  logic [GROUP-1:0]  grp_s    [STAGES];
  logic              grp_cout [STAGES];
  logic              grp_g    [STAGES];
  logic              grp_p    [STAGES];
  logic [STAGES-1:0] adv;
  logic              out_adv, accept, carry_out, overflow, diff_msb;
  result_t           res_reg, res_next;
  logic              out_valid_reg;

  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      sub_group #(.GROUP(GROUP)) u_group (
        .a    (st_reg[gi].a[gi*GROUP +: GROUP]),
        .nb   (st_reg[gi].nb[gi*GROUP +: GROUP]),
        .cin  (st_reg[gi].carry),
        .s    (grp_s[gi]),
        .cout (grp_cout[gi]),
        .g    (grp_g[gi]),
        .p    (grp_p[gi])
      );
    end
  endgenerate

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      st_next[k]                        = st_reg[k];
      st_next[k].diff[k*GROUP +: GROUP] = grp_s[k];
      st_next[k].carry                  = grp_cout[k];
    end
  end

  // Bubble-collapsing: a stage moves on when its successor is empty or moving.
  always_comb begin
    out_adv   = !out_valid_reg || out_ready;
    adv       = '0;
    adv[LAST] = st_reg[LAST].valid && out_adv;
    for (int k = LAST - 1; k >= 0; k--) begin
      adv[k] = st_reg[k].valid && (!st_reg[k+1].valid || adv[k+1]);
    end
  end

  assign in_ready = !rst && (!st_reg[0].valid || adv[0]);
  assign accept   = in_valid && in_ready;

  always_comb begin
    res_next        = '0;
    carry_out       = grp_g[LAST] | (grp_p[LAST] & st_reg[LAST].carry);
    diff_msb        = st_next[LAST].diff[WIDTH-1];
    overflow        = (st_reg[LAST].a[WIDTH-1] ^ ~st_reg[LAST].nb[WIDTH-1])
                    & (st_reg[LAST].a[WIDTH-1] ^ diff_msb);
    res_next.diff   = st_next[LAST].diff;
    res_next.borrow = !carry_out;
    res_next.lt_s   = diff_msb ^ overflow;
    res_next.zero   = (st_next[LAST].diff == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        st_reg[k] <= '0;
      end
      res_reg       <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      if (accept) begin
        st_reg[0] <= '{valid: 1'b1, carry: 1'b1, diff: '0, a: in_a, nb: ~in_b};
      end else if (adv[0]) begin
        st_reg[0].valid <= 1'b0;
      end
      for (int k = 1; k < STAGES; k++) begin
        if (adv[k-1]) begin
          st_reg[k] <= st_next[k-1];
        end else if (adv[k]) begin
          st_reg[k].valid <= 1'b0;
        end
      end
      // Result fields are zeroed whenever the output slot empties.
      if (out_adv) begin
        out_valid_reg <= st_reg[LAST].valid;
        res_reg       <= st_reg[LAST].valid ? res_next : '0;
      end
    end
  end

  assign out_valid  = out_valid_reg;
  assign out_diff   = res_reg.diff;
  assign out_borrow = res_reg.borrow;
  assign out_lt_s   = res_reg.lt_s;
  assign out_zero   = res_reg.zero;

endmodule

// File: tb/tb_sub_pipe.sv
// Self-checking bench for sub_pipe: constant vectors, hand-written flow-control
// sequences and a randomized stream scored against an arithmetic model.
module tb_sub_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_diff;
  logic        out_borrow;
  logic        out_lt_s;
  logic        out_zero;

  sub_pipe dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_diff   (out_diff),
    .out_borrow (out_borrow),
    .out_lt_s   (out_lt_s),
    .out_zero   (out_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] diff;
    logic        borrow;
    logic        lt_s;
    logic        zero;
  } vec_t;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
  } op_t;

  int  n_cmp = 0;
  int  n_bad = 0;
  int  n_txn = 0;
  op_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operands.
  function automatic logic [18:0] model(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] d;
    d = a - b;
    return {d, (a < b), ($signed(a) < $signed(b)), (a == b)};
  endfunction

  function automatic logic [18:0] observed();
    return {out_diff, out_borrow, out_lt_s, out_zero};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: handshakes sampled mid-cycle, results checked in order.
  logic        hold_prev = 1'b0;
  logic [18:0] prev_out;
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_stable", 32'(observed()), 32'(prev_out));
      end
      if (!out_valid) begin
        check("idle_zero", 32'(observed()), 32'd0);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 32'd1, 32'd0);
        end else begin
          op_t op;
          op = exp_q.pop_front();
          check("stream_result", 32'(observed()), 32'(model(op.a, op.b)));
          $display("txn %0d: %h - %h -> diff=%h borrow=%0d lt_s=%0d zero=%0d",
                   n_txn, op.a, op.b, out_diff, out_borrow, out_lt_s, out_zero);
          n_txn++;
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back('{a: in_a, b: in_b});
      end
      hold_prev = out_valid && !out_ready;
      prev_out  = observed();
    end
  end

  task automatic run_vec(input int idx, input vec_t v);
    int cyc;
    tick();
    in_valid  = 1'b1;
    in_a      = v.a;
    in_b      = v.b;
    out_ready = 1'b1;
    #1;
    check($sformatf("vec%0d_in_ready", idx), 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 12) begin
      tick();
      cyc++;
    end
    check($sformatf("vec%0d_latency", idx), 32'(cyc), 32'd4);
    check($sformatf("vec%0d_result", idx), 32'(observed()),
          32'({v.diff, v.borrow, v.lt_s, v.zero}));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[8];
    logic [19:0] ov_hist;
    int          acc;
    int          cnt;
    logic        took;

    vecs[0] = '{a: 16'h1234, b: 16'h0234, diff: 16'h1000, borrow: 0, lt_s: 0, zero: 0};
    vecs[1] = '{a: 16'h0000, b: 16'h0001, diff: 16'hFFFF, borrow: 1, lt_s: 1, zero: 0};
    vecs[2] = '{a: 16'h5A5A, b: 16'h5A5A, diff: 16'h0000, borrow: 0, lt_s: 0, zero: 1};
    vecs[3] = '{a: 16'h8000, b: 16'h0001, diff: 16'h7FFF, borrow: 0, lt_s: 1, zero: 0};
    vecs[4] = '{a: 16'h7FFF, b: 16'hFFFF, diff: 16'h8000, borrow: 1, lt_s: 0, zero: 0};
    vecs[5] = '{a: 16'h0001, b: 16'h8000, diff: 16'h8001, borrow: 1, lt_s: 0, zero: 0};
    vecs[6] = '{a: 16'hFFFF, b: 16'h0000, diff: 16'hFFFF, borrow: 0, lt_s: 1, zero: 0};
    vecs[7] = '{a: 16'h0F0F, b: 16'hF0F0, diff: 16'h1E1F, borrow: 1, lt_s: 0, zero: 0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0;
    tick();
    tick();
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(observed()), 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // Eight back-to-back operations: results on cycles 4..11 after the first accept.
    tick();
    out_ready = 1'b1;
    ov_hist = '0;
    for (int i = 0; i < 20; i++) begin
      in_valid = (i < 8);
      in_a     = 16'($urandom);
      in_b     = 16'($urandom);
      #1;
      if (i < 8) check("b2b_in_ready", 32'(in_ready), 32'd1);
      tick();
      ov_hist[i] = out_valid;
    end
    in_valid = 1'b0;
    check("b2b_valid_pattern", 32'(ov_hist), 32'h00FF0);

    // Backpressure: five slots fill, then in_ready drops.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_a      = 16'($urandom);
    in_b      = 16'($urandom);
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      took = in_ready;
      tick();
      if (took) begin
        acc++;
        in_a = 16'($urandom);
        in_b = 16'($urandom);
      end
    end
    #1;
    check("bp_accepts", 32'(acc), 32'd5);
    check("bp_in_ready", 32'(in_ready), 32'd0);

    // Release: full-rate flow resumes with one accept and one result per cycle.
    out_ready = 1'b1;
    acc = 0;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      #1;
      took = in_ready;
      if (out_valid) cnt++;
      tick();
      if (took) begin
        acc++;
        in_a = 16'($urandom);
        in_b = 16'($urandom);
      end
    end
    check("release_accepts", 32'(acc), 32'd12);
    check("release_outputs", 32'(cnt), 32'd12);
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) tick();

    // Reset with three operations in flight.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_a     = 16'($urandom);
      in_b     = 16'($urandom);
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid) cnt++;
    end
    check("midrst_no_stale", 32'(cnt), 32'd0);
    run_vec(100, vecs[0]);
    run_vec(101, vecs[4]);

    // Randomized traffic with random backpressure; the scoreboard checks results.
    in_valid = 1'b0;
    took = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!in_valid || took) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_a     = ($urandom_range(0, 7) == 0) ? in_b : 16'($urandom);
        in_b     = 16'($urandom);
      end
      out_ready = ($urandom_range(0, 9) < 7);
      #1;
      took = in_valid && in_ready;
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cnt = 0;
    while (exp_q.size() != 0 && cnt < 50) begin
      tick();
      cnt++;
    end
    tick();
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    check("drain_out_valid", 32'(out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
